// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with write bypass, link write and per-register busy scoreboard
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = (1 << ADDR_W) - 1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [ADDR_W-1:0]       ReadReg1,
    input  logic [ADDR_W-1:0]       ReadReg2,
    output logic [DATA_W-1:0]       DataRead1,
    output logic [DATA_W-1:0]       DataRead2,
    input  logic [ADDR_W-1:0]       WriteReg,
    input  logic [DATA_W-1:0]       WriteData,
    input  logic                    RegWrite,
    input  logic                    Jal,
    input  logic [DATA_W-1:0]       LinkAddr,
    input  logic                    IssueValid,
    input  logic [ADDR_W-1:0]       IssueReg,
    output logic                    Stall,
    output logic [(1<<ADDR_W)-1:0]  BusyVec,
    input  logic [ADDR_W-1:0]       DbgReg,
    output logic [DATA_W-1:0]       DbgData
);
    localparam int NREGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_busy;
    logic [NREGS-1:0]  w_busy_nxt;
    logic [DATA_W-1:0] w_link_data;
    logic              w_byp1;
    logic              w_byp2;

    assign w_link_data = LinkAddr + DATA_W'(1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (RegWrite && (WriteReg != '0)) begin
                r_regs[WriteReg] <= WriteData;
            end
            // Issued after the writeback so the link write wins on a collision.
            if (Jal && (LINK_A != '0)) begin
                r_regs[LINK_A] <= w_link_data;
            end
        end
    end

    always_comb begin
        w_busy_nxt = r_busy;
        if (RegWrite) begin
            w_busy_nxt[WriteReg] = 1'b0;
        end
        if (Jal) begin
            w_busy_nxt[LINK_A] = 1'b0;
        end
        // A fresh producer issued this cycle outranks the retiring one.
        if (IssueValid && (IssueReg != '0)) begin
            w_busy_nxt[IssueReg] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    function automatic logic [DATA_W-1:0] f_read(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] arr
    );
        if (a == '0) begin
            return '0;
        end else if (Jal && (a == LINK_A)) begin
            return w_link_data;
        end else if (RegWrite && (WriteReg == a)) begin
            return WriteData;
        end else begin
            return arr;
        end
    endfunction

    always_comb begin
        DataRead1 = f_read(ReadReg1, r_regs[ReadReg1]);
        DataRead2 = f_read(ReadReg2, r_regs[ReadReg2]);
        DbgData   = (DbgReg == '0) ? '0 : r_regs[DbgReg];
    end

    assign w_byp1 = (Jal && (ReadReg1 == LINK_A)) || (RegWrite && (WriteReg == ReadReg1));
    assign w_byp2 = (Jal && (ReadReg2 == LINK_A)) || (RegWrite && (WriteReg == ReadReg2));

    assign Stall = ((ReadReg1 != '0) && r_busy[ReadReg1] && !w_byp1) ||
                   ((ReadReg2 != '0) && r_busy[ReadReg2] && !w_byp2);

    assign BusyVec = r_busy;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed and randomized checks of reg_file_sb against a behavioural model
module tb_reg_file_sb;
    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  ReadReg1, ReadReg2, WriteReg, IssueReg, DbgReg;
    logic [31:0] DataRead1, DataRead2, WriteData, LinkAddr, DbgData;
    logic        RegWrite, Jal, IssueValid, Stall;
    logic [31:0] BusyVec;

    reg_file_sb dut (
        .Clk(Clk), .Reset(Reset),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .DataRead1(DataRead1), .DataRead2(DataRead2),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
        .Jal(Jal), .LinkAddr(LinkAddr),
        .IssueValid(IssueValid), .IssueReg(IssueReg),
        .Stall(Stall), .BusyVec(BusyVec),
        .DbgReg(DbgReg), .DbgData(DbgData)
    );

    always #5 Clk = ~Clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (Jal && a == 31) return LinkAddr + 32'd1;
        if (RegWrite && WriteReg == a) return WriteData;
        return m_regs[a];
    endfunction

    function automatic logic m_pending(input logic [4:0] a);
        logic written;
        written = (Jal && a == 31) || (RegWrite && WriteReg == a);
        return (a != 0) && m_busy[a] && !written;
    endfunction

    task automatic idle();
        Reset = 0; RegWrite = 0; Jal = 0; IssueValid = 0;
        ReadReg1 = 0; ReadReg2 = 0; WriteReg = 0; IssueReg = 0; DbgReg = 0;
        WriteData = 0; LinkAddr = 0;
    endtask

    // Compare all outputs with the model, then advance one clock and update the model.
    task automatic step();
        #1;
        chk("rd1", 64'(DataRead1), 64'(m_read(ReadReg1)));
        chk("rd2", 64'(DataRead2), 64'(m_read(ReadReg2)));
        chk("dbg", 64'(DbgData), 64'((DbgReg == 0) ? 32'h0 : m_regs[DbgReg]));
        chk("stall", 64'(Stall), 64'(m_pending(ReadReg1) || m_pending(ReadReg2)));
        chk("busyvec", 64'(BusyVec), 64'(m_busy));
        @(posedge Clk);
        if (Reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_busy = 32'h0;
        end else begin
            if (RegWrite && WriteReg != 0) m_regs[WriteReg] = WriteData;
            if (Jal) m_regs[31] = LinkAddr + 32'd1;
            if (RegWrite) m_busy[WriteReg] = 1'b0;
            if (Jal) m_busy[31] = 1'b0;
            if (IssueValid && IssueReg != 0) m_busy[IssueReg] = 1'b1;
        end
        @(negedge Clk);
    endtask

    function automatic logic [4:0] rnd_addr();
        logic [4:0] hot [5];
        hot[0] = 0; hot[1] = 1; hot[2] = 2; hot[3] = 8; hot[4] = 31;
        if ($urandom_range(0, 1) == 0) return hot[$urandom_range(0, 4)];
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_busy = 32'h0;
        idle();
        Reset = 1;
        @(negedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        idle();
        Reset = 1;
        step();
        idle();

        for (int a = 0; a < 32; a++) begin
            ReadReg1 = 5'(a); ReadReg2 = 5'(31 - a); DbgReg = 5'(a);
            #1;
            chk("rst_rd1", 64'(DataRead1), 64'h0);
            chk("rst_rd2", 64'(DataRead2), 64'h0);
            chk("rst_stall", 64'(Stall), 64'h0);
            chk("rst_busy", 64'(BusyVec), 64'h0);
            step();
        end

        idle();
        RegWrite = 1; WriteReg = 5; WriteData = 32'hDEADBEEF; ReadReg1 = 5; DbgReg = 5;
        #1;
        chk("byp_rd1", 64'(DataRead1), 64'hDEADBEEF);
        chk("byp_dbg_now", 64'(DbgData), 64'h0);
        step();
        idle(); DbgReg = 5;
        #1;
        chk("byp_dbg_next", 64'(DbgData), 64'hDEADBEEF);
        step();

        idle(); RegWrite = 1; WriteReg = 0; WriteData = 32'h1234;
        step();
        idle(); ReadReg1 = 0;
        #1;
        chk("r0_zero", 64'(DataRead1), 64'h0);
        step();

        idle();
        Jal = 1; LinkAddr = 32'hFFFFFFFF; RegWrite = 1; WriteReg = 31; WriteData = 7; ReadReg2 = 31;
        #1;
        chk("jal_rd2", 64'(DataRead2), 64'h0);
        step();
        idle(); DbgReg = 31;
        #1;
        chk("jal_wrap", 64'(DbgData), 64'h0);
        step();

        idle(); IssueValid = 1; IssueReg = 8;
        step();
        idle(); ReadReg1 = 8;
        #1;
        chk("sb_stall", 64'(Stall), 64'h1);
        step();
        idle(); ReadReg1 = 8; RegWrite = 1; WriteReg = 8; WriteData = 32'h55;
        #1;
        chk("sb_wb_stall", 64'(Stall), 64'h0);
        chk("sb_wb_rd1", 64'(DataRead1), 64'h55);
        step();
        idle();
        #1;
        chk("sb_busy8", 64'(BusyVec[8]), 64'h0);
        step();

        idle(); IssueValid = 1; IssueReg = 9; RegWrite = 1; WriteReg = 9; WriteData = 32'h99;
        step();
        idle();
        #1;
        chk("set_wins", 64'(BusyVec[9]), 64'h1);
        Reset = 1; RegWrite = 1; WriteReg = 3; WriteData = 32'h33; IssueValid = 1; IssueReg = 4;
        step();
        idle(); DbgReg = 3;
        #1;
        chk("rst_busyvec", 64'(BusyVec), 64'h0);
        chk("rst_drop_wb", 64'(DbgData), 64'h0);
        step();

        for (int n = 0; n < 3000; n++) begin
            idle();
            Reset      = ($urandom_range(0, 199) == 0);
            RegWrite   = $urandom_range(0, 1) == 1;
            Jal        = $urandom_range(0, 7) == 0;
            IssueValid = $urandom_range(0, 2) == 0;
            WriteReg   = rnd_addr();
            IssueReg   = rnd_addr();
            ReadReg1   = rnd_addr();
            ReadReg2   = rnd_addr();
            DbgReg     = rnd_addr();
            WriteData  = $urandom;
            LinkAddr   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; register count NREGS = 2**ADDR_W.
REQ-003 SHALL have parameter LINK_REG, default NREGS-1, link register index written by Jal.
REQ-004 SHALL have one clock and a synchronous, active-high reset, with ports listed first as below.
 Clk  in  1  rising-edge clock for all state.
 Reset  in  1  synchronous, active-high reset.
 ReadReg1  in  ADDR_W  read port 1 address.
 ReadReg2  in  ADDR_W  read port 2 address.
 DataRead1  out  DATA_W  read port 1 data.
 DataRead2  out  DATA_W  read port 2 data.
 WriteReg  in  ADDR_W  writeback address.
 WriteData  in  DATA_W  writeback data.
 RegWrite  in  1  writeback enable.
 Jal  in  1  link write enable.
 LinkAddr  in  DATA_W  current instruction address for link.
 IssueValid  in  1  an issued instruction will later write IssueReg.
 IssueReg  in  ADDR_W  destination of the issued instruction.
 Stall  out  1  a read operand is pending (busy and not being written back).
 BusyVec  out  NREGS  per-register pending-write bits.
 DbgReg  in  ADDR_W  debug read address.
 DbgData  out  DATA_W  debug read data; raw array, no bypass.

Function
REQ-005 SHALL hold NREGS registers of DATA_W bits; register 0 SHALL always read 0, and writes to it SHALL be ignored.
REQ-006 SHALL write WriteData to WriteReg on a rising Clk edge when RegWrite=1.
REQ-007 SHALL write (LinkAddr+1) mod 2**DATA_W to LINK_REG on a rising Clk edge when Jal=1.
REQ-008 SHALL give Jal priority when RegWrite=1, WriteReg=LINK_REG and Jal=1 in the same cycle; LINK_REG gets LinkAddr+1.
REQ-009 SHALL drive DataReadN combinationally, with zero-cycle latency.
REQ-010 SHALL apply this priority for DataReadN: ReadRegN=0 -> 0; else Jal and ReadRegN=LINK_REG -> LinkAddr+1; else RegWrite and WriteReg=ReadRegN -> WriteData; else array contents.
REQ-011 SHALL drive DbgData combinationally from the array only, with DbgReg=0 giving 0.
REQ-012 SHALL keep one busy bit per register; bit 0 SHALL always be 0.
REQ-013 SHALL set busy[IssueReg] on a rising edge when IssueValid=1 and IssueReg!=0.
REQ-014 SHALL clear busy[WriteReg] on a rising edge when RegWrite=1, and busy[LINK_REG] when Jal=1.
REQ-015 SHALL let set win over clear when issue and writeback hit the same register in the same cycle (a new producer is pending).
REQ-016 SHALL drive Stall = OR over N of (ReadRegN!=0 and busy[ReadRegN] and the register is not being written back this cycle per REQ-010); combinational.
REQ-017 SHALL drive BusyVec directly from the busy bits.
REQ-018 SHALL apply writes and busy updates for the same register independently of any read-port activity; no arbitration or back-pressure on writeback.

Reset
REQ-019 SHALL, on a rising edge with Reset=1, clear all registers and all busy bits to 0, overriding RegWrite, Jal and IssueValid in that cycle.
REQ-020 SHALL, after reset, give DataRead1=DataRead2=DbgData=0, Stall=0 and BusyVec=0 for any address.
REQ-021 SHALL discard a pending writeback if reset is asserted mid-operation; that writeback SHALL NOT take effect after reset.

Verification
REQ-022 Reset, then read all 32 addresses on both ports -> all 0, Stall=0, BusyVec=0.
REQ-023 RegWrite WriteReg=5 WriteData=0xDEADBEEF with ReadReg1=5 in the same cycle -> DataRead1=0xDEADBEEF that cycle; DbgReg=5 gives 0 that cycle and 0xDEADBEEF the next.
REQ-024 RegWrite WriteReg=0 WriteData=0x1234 -> ReadReg1=0 returns 0 the next cycle.
REQ-025 Jal=1 LinkAddr=0xFFFFFFFF with RegWrite WriteReg=31 WriteData=7 -> reg 31 = 0x00000000 (wrap, Jal wins); ReadReg2=31 same cycle gives 0.
REQ-026 Issue reg 8; next cycle ReadReg1=8 -> Stall=1; then RegWrite 8=0x55 -> Stall=0 and DataRead1=0x55 that cycle, busy[8]=0 after.
REQ-027 Issue reg 9 and RegWrite 9 in the same cycle -> busy[9]=1 after the edge; Reset with busy bits set -> BusyVec=0 after the edge.
